// File: rtl/utmi_tx_serializer.sv
// utmi_tx_serializer: transmit-side bit engine for a full-speed UTMI block.
// Takes bytes over tx_valid/tx_ready, prepends SYNC, serialises LSB-first at
// one bit per PRESCALE clocks with bit stuffing and NRZI, then appends EOP.
// Optional feature macro: TX_ABORT_EN adds the tx_abort input, which ends the
// packet with seven unstuffed 1 bits (a forced stuff error) followed by EOP.
module utmi_tx_serializer #(
  parameter int PRESCALE  = 4,
  parameter int STUFF_LEN = 6
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
`ifdef TX_ABORT_EN
  input  logic       tx_abort,
`endif
  output logic       tx_ready,
  output logic       dp,
  output logic       dm,
  output logic       oe,
  output logic       busy
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int OW = $clog2(STUFF_LEN + 1);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
`ifdef TX_ABORT_EN
    ABORT,
`endif
    EOP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;        // position inside the current bit period
  logic [OW-1:0] ones;       // run of 1 bits on the line, stuff bits included
  logic [6:0]    shift;      // bits of the current byte still to be sent
  logic [2:0]    bit_idx;    // bit index in SYNC/DATA, period count in EOP/abort
  logic          level;      // NRZI line level, 1 = J, 0 = K

  logic          bit_tick;
  logic          stuff_next;
  logic          send_bit;
  logic          new_level;
  logic [OW-1:0] new_ones;

`ifdef TX_ABORT_EN
  logic abort_pending;
  logic abort_now;
  assign abort_now = abort_pending | tx_abort;
`endif

  // Next-bit decode: which bit would go out next, and its NRZI/ones effect.
  always_comb begin
    bit_tick   = (cnt == CW'(PRESCALE - 1));
    stuff_next = (ones == OW'(STUFF_LEN));
    // After bit 7 the next bit is bit 0 of the byte being loaded.
    send_bit   = (bit_idx == 3'd7) ? tx_data[0] : shift[0];
    new_level  = send_bit ? level : ~level;
    new_ones   = send_bit ? ones + OW'(1) : '0;
  end

  // Packet FSM with bit timing, stuffing, NRZI and registered line outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      cnt      <= '0;
      ones     <= '0;
      shift    <= '0;
      bit_idx  <= '0;
      level    <= 1'b1;
      tx_ready <= 1'b0;
      dp       <= 1'b1;
      dm       <= 1'b0;
      oe       <= 1'b0;
      busy     <= 1'b0;
`ifdef TX_ABORT_EN
      abort_pending <= 1'b0;
`endif
    end else begin
      tx_ready <= 1'b0;
      cnt      <= (state == IDLE || bit_tick) ? '0 : cnt + CW'(1);
`ifdef TX_ABORT_EN
      abort_pending <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (tx_valid) begin
            state   <= SYNC;
            oe      <= 1'b1;
            busy    <= 1'b1;
            // SYNC 8'h80: bit 0 goes out now (J->K), bits 1..7 wait here.
            shift   <= 7'h40;
            bit_idx <= 3'd0;
            ones    <= '0;
            level   <= 1'b0;
            dp      <= 1'b0;
            dm      <= 1'b1;
          end
        end
        SYNC, DATA: begin
`ifdef TX_ABORT_EN
          abort_pending <= abort_now & ~bit_tick;
`endif
          if (bit_tick) begin
`ifdef TX_ABORT_EN
            if (abort_now) begin
              // Line holds: the first of seven forced 1 bits.
              state   <= ABORT;
              bit_idx <= 3'd0;
            end else
`endif
            if (stuff_next) begin
              // Stuffed 0 toggles the line; shift register does not advance.
              ones  <= '0;
              level <= ~level;
              dp    <= ~level;
              dm    <= level;
            end else if (bit_idx == 3'd7) begin
              // Load point: end of SYNC or of a byte (and its stuff bit).
              if (tx_valid) begin
                state    <= DATA;
                shift    <= tx_data[7:1];
                bit_idx  <= 3'd0;
                tx_ready <= 1'b1;
                ones     <= new_ones;
                level    <= new_level;
                dp       <= new_level;
                dm       <= ~new_level;
              end else begin
                state   <= EOP;
                bit_idx <= 3'd0;
                dp      <= 1'b0;
                dm      <= 1'b0;
              end
            end else begin
              shift   <= shift >> 1;
              bit_idx <= bit_idx + 3'd1;
              ones    <= new_ones;
              level   <= new_level;
              dp      <= new_level;
              dm      <= ~new_level;
            end
          end
        end
`ifdef TX_ABORT_EN
        ABORT: begin
          if (bit_tick) begin
            if (bit_idx == 3'd6) begin
              state   <= EOP;
              bit_idx <= 3'd0;
              dp      <= 1'b0;
              dm      <= 1'b0;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
`endif
        EOP: begin
          // SE0, SE0, then J; release the bus when the J period ends.
          if (bit_tick) begin
            if (bit_idx == 3'd2) begin
              state   <= IDLE;
              oe      <= 1'b0;
              busy    <= 1'b0;
              bit_idx <= 3'd0;
              ones    <= '0;
              level   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              if (bit_idx == 3'd1) begin
                dp <= 1'b1;
                dm <= 1'b0;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_utmi_tx_serializer.sv
// Self-checking bench for utmi_tx_serializer: directed and random packets are
// compared symbol by symbol against a bit-level model of SYNC, stuffing, NRZI
// and EOP; the observed line is also NRZI-decoded back into bytes.
`timescale 1ns/1ps
module tb_utmi_tx_serializer;
  localparam int P  = 4;
  localparam int SL = 6;
  localparam logic [1:0] SYM_J   = 2'b10;
  localparam logic [1:0] SYM_K   = 2'b01;
  localparam logic [1:0] SYM_SE0 = 2'b00;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] tx_data;
  logic       tx_valid;
`ifdef TX_ABORT_EN
  logic       tx_abort;
`endif
  logic       tx_ready, dp, dm, oe, busy;

  int vectors     = 0;
  int miscompares = 0;
  int abort_at    = -1;

  logic [7:0] pkt[$];
  logic [1:0] exp_sym[$];
  int         exp_ready[$];
  logic [1:0] obs_line[$];
  logic       obs_oe[$];
  int         obs_ready[$];
  int         obs_oe_cnt, obs_busy_cnt;
  logic       mdl_level;
  int         mdl_ones;

  utmi_tx_serializer #(.PRESCALE(P), .STUFF_LEN(SL)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
`ifdef TX_ABORT_EN
    .tx_abort (tx_abort),
`endif
    .tx_ready (tx_ready),
    .dp       (dp),
    .dm       (dm),
    .oe       (oe),
    .busy     (busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: one line symbol per transmitted bit.
  task automatic mdl_bit(input logic b);
    if (!b) mdl_level = ~mdl_level;
    exp_sym.push_back(mdl_level ? SYM_J : SYM_K);
    mdl_ones = b ? mdl_ones + 1 : 0;
  endtask

  task automatic mdl_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      mdl_bit(v[i]);
      if (mdl_ones == SL) mdl_bit(1'b0);
    end
  endtask

  task automatic build_model(input int abort_sym);
    logic [1:0] held;
    exp_sym.delete();
    exp_ready.delete();
    mdl_level = 1'b1;
    mdl_ones  = 0;
    mdl_byte(8'h80);
    foreach (pkt[i]) begin
      exp_ready.push_back(exp_sym.size() * P);
      mdl_byte(pkt[i]);
    end
    if (abort_sym >= 0) begin
      while (exp_sym.size() > abort_sym) void'(exp_sym.pop_back());
      while (exp_ready.size() > 0 && exp_ready[$] >= abort_sym * P) void'(exp_ready.pop_back());
      held = exp_sym[$];
      repeat (7) exp_sym.push_back(held);
    end
    exp_sym.push_back(SYM_SE0);
    exp_sym.push_back(SYM_SE0);
    exp_sym.push_back(SYM_J);
  endtask

  // Drives one packet cycle by cycle and records the line until oe drops.
  task automatic run_pkt(input string name, input bit glitch, input int rst_cyc,
                         output bit was_reset);
    int idx;
    int s;
    bit done;
    obs_line.delete();
    obs_oe.delete();
    obs_ready.delete();
    obs_oe_cnt   = 0;
    obs_busy_cnt = 0;
    was_reset    = 1'b0;
    idx  = 0;
    s    = 0;
    done = 1'b0;
    @(negedge CLK);
    tx_data  = (pkt.size() > 0) ? pkt[0] : 8'($urandom);
    tx_valid = 1'b1;
    while (!done) begin
      @(negedge CLK);
      obs_line.push_back({dp, dm});
      obs_oe.push_back(oe);
      if (oe) obs_oe_cnt++;
      if (busy) obs_busy_cnt++;
      if (tx_ready) begin
        obs_ready.push_back(s);
        idx++;
      end
      if ((s > 0 && !oe) || s > 2000) done = 1'b1;
      tx_valid = (idx < pkt.size());
      if (glitch && s >= 40 && s < 47) tx_valid = 1'b0;
      tx_data = (idx < pkt.size()) ? pkt[idx] : 8'($urandom);
`ifdef TX_ABORT_EN
      tx_abort = (s + 1 == abort_at);
`endif
      if (s + 1 == rst_cyc) begin
        RST = 1'b0;
        #1;
        chk({name, "_rst_dp"}, dp, 1);
        chk({name, "_rst_dm"}, dm, 0);
        chk({name, "_rst_oe"}, oe, 0);
        chk({name, "_rst_busy"}, busy, 0);
        chk({name, "_rst_ready"}, tx_ready, 0);
        @(negedge CLK);
        tx_valid = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        was_reset = 1'b1;
        done = 1'b1;
      end
      s++;
    end
    chk({name, "_timeout"}, (s > 2000) ? 1 : 0, 0);
    tx_valid = 1'b0;
`ifdef TX_ABORT_EN
    tx_abort = 1'b0;
`endif
  endtask

  task automatic do_pkt(input string name, input bit glitch, input int rst_cyc);
    bit         was_reset;
    int         abort_sym;
    logic [1:0] sv, cur, prev;
    logic       bits[$];
    logic [7:0] dbyte;
    int         ones;
    abort_sym = (abort_at >= 0) ? abort_at / P + 1 : -1;
    build_model(abort_sym);
    run_pkt(name, glitch, rst_cyc, was_reset);
    if (was_reset) begin
      $display("pkt %s: reset applied mid-packet", name);
      return;
    end
    chk({name, "_oe_latency"}, obs_oe[0], 1);
    chk({name, "_oe_cycles"}, obs_oe_cnt, exp_sym.size() * P);
    chk({name, "_busy_cycles"}, obs_busy_cnt, exp_sym.size() * P);
    for (int k = 0; k < exp_sym.size(); k++) begin
      sv = (k * P < obs_line.size()) ? obs_line[k * P] : 2'b11;
      for (int j = 1; j < P; j++)
        if (k * P + j >= obs_line.size() || obs_line[k * P + j] !== sv) sv = 2'b11;
      chk($sformatf("%s_sym%0d", name, k), sv, exp_sym[k]);
    end
    chk({name, "_ready_n"}, obs_ready.size(), exp_ready.size());
    for (int i = 0; i < exp_ready.size() && i < obs_ready.size(); i++)
      chk($sformatf("%s_ready%0d", name, i), obs_ready[i], exp_ready[i]);
    chk({name, "_idle_j"}, obs_line[$], SYM_J);
    if (abort_at < 0) begin
      prev = SYM_J;
      ones = 0;
      for (int k = 0; k * P + P / 2 < obs_line.size(); k++) begin
        cur = obs_line[k * P + P / 2];
        if (cur === SYM_SE0 || (cur !== SYM_J && cur !== SYM_K)) break;
        if (ones == SL) ones = 0;
        else begin
          bits.push_back(cur === prev);
          ones = (cur === prev) ? ones + 1 : 0;
        end
        prev = cur;
      end
      chk({name, "_dec_len"}, (bits.size() >= 8) ? (bits.size() - 8) / 8 : 0, pkt.size());
      for (int i = 0; i < pkt.size() && 8 * i + 15 < bits.size(); i++) begin
        for (int j = 0; j < 8; j++) dbyte[j] = bits[8 + 8 * i + j];
        chk($sformatf("%s_dec%0d", name, i), dbyte, pkt[i]);
      end
    end
    $display("pkt %s: %0d bytes, %0d symbols, oe %0d cycles", name, pkt.size(),
             exp_sym.size(), obs_oe_cnt);
  endtask

  function automatic logic [7:0] rnd_byte();
    return ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
  endfunction

  initial begin
    RST      = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
`ifdef TX_ABORT_EN
    tx_abort = 1'b0;
`endif
    repeat (3) @(negedge CLK);
    chk("reset_ready", tx_ready, 0);
    chk("reset_oe", oe, 0);
    chk("reset_busy", busy, 0);
    chk("reset_dp", dp, 1);
    chk("reset_dm", dm, 0);
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    pkt = '{8'h00};
    do_pkt("byte00", 1'b0, -1);
    chk("byte00_oe76", obs_oe_cnt, 76);
    chk("byte00_ready32", (obs_ready.size() > 0) ? obs_ready[0] : -1, 32);

    pkt = '{8'hFF};
    do_pkt("byteFF", 1'b0, -1);
    chk("byteFF_oe80", obs_oe_cnt, 80);

    pkt = '{8'hA5, 8'h3C, 8'hFF};
    do_pkt("three", 1'b0, -1);
    chk("three_gap", (obs_ready.size() > 1) ? obs_ready[1] - obs_ready[0] : -1, 32);
    chk("three_oe144", obs_oe_cnt, 144);

    pkt.delete();
    do_pkt("nobyte", 1'b0, -1);
    chk("nobyte_oe44", obs_oe_cnt, 44);

    pkt = '{rnd_byte(), rnd_byte()};
    do_pkt("glitch", 1'b1, -1);

    pkt = '{rnd_byte(), rnd_byte(), rnd_byte()};
    do_pkt("midrst", 1'b0, 75);
    pkt = '{rnd_byte()};
    do_pkt("afterrst", 1'b0, -1);

    for (int n = 0; n < 8; n++) begin
      pkt.delete();
      repeat ($urandom_range(1, 4)) pkt.push_back(rnd_byte());
      do_pkt($sformatf("rand%0d", n), 1'b0, -1);
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end

`ifdef TX_ABORT_EN
    abort_at = 45;
    pkt = '{rnd_byte(), rnd_byte()};
    do_pkt("abort", 1'b0, -1);
    chk("abort_ready_n", obs_ready.size(), 1);
    abort_at = -1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
